// File: rtl/mem_pkg.sv
// Shared definitions for the block-wide memory responder: FSM state
// encoding, address-split helpers and the default block type.
package mem_pkg;

  // state        | meaning
  // ST_INIT      | zero-filling the array one block per cycle, requests ignored
  // ST_IDLE      | accepting reads and direct writes, draining the write buffer
  // ST_READ_WAIT | latency counter running toward the read response
  // ST_RELEASE   | response sent, waiting for mem_read to drop
  typedef enum logic [1:0] {
    ST_INIT      = 2'd0,
    ST_IDLE      = 2'd1,
    ST_READ_WAIT = 2'd2,
    ST_RELEASE   = 2'd3
  } state_t;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_BLOCK_SIZE = 32;

  // One block at the default geometry, word 0 in the low slice.
  typedef logic [DEF_BLOCK_SIZE-1:0][DEF_DATA_WIDTH-1:0] block_t;

  // Number of address bits that select a word inside a block.
  function automatic int offset_width(input int block_size);
    return (block_size > 1) ? $clog2(block_size) : 0;
  endfunction

  // Number of address bits that select a block.
  function automatic int index_width(input int addr_width, input int block_size);
    return addr_width - offset_width(block_size);
  endfunction

endpackage

// File: rtl/mem_block_array.sv
// Single-port block-wide storage: one block index shared by the synchronous
// write and the combinational read. Contents are never reset.
module mem_block_array #(
  parameter int DATA_WIDTH  = 32,
  parameter int BLOCK_SIZE  = 32,
  parameter int INDEX_WIDTH = 6
) (
  input  logic                                 clk,
  input  logic                                 we,
  input  logic [INDEX_WIDTH-1:0]               addr,
  input  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] wdata,
  output logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] rdata
);

  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] mem [2**INDEX_WIDTH];

  // Whole-block write on the rising edge.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_block_responder.sv
// Block-granular memory responder for a cache: fixed-latency block reads,
// zero-latency write-through, and a one-entry posted write buffer for writes
// that land while a read is in flight.
// Build option: define MEM_ZERO_INIT_EN to zero-fill the array after reset
// (mem_busy high during the fill); otherwise the array powers up undefined.
//
// state        | meaning
// ST_INIT      | zero fill, one block per cycle (MEM_ZERO_INIT_EN only)
// ST_IDLE      | accept read / direct write, commit buffered write
// ST_READ_WAIT | down-counter running, response at terminal count
// ST_RELEASE   | ignore the stale mem_read until it is sampled low
import mem_pkg::*;

module mem_block_responder #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 11,
  parameter int BLOCK_SIZE   = 32,
  parameter int READ_LATENCY = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [ADDR_WIDTH-1:0]                mem_addr,
  input  logic                                 mem_read,
  input  logic                                 mem_write,
  input  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] mem_data_out,
  output logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] mem_data_block,
  output logic                                 mem_ready,
  output logic                                 mem_busy,
  output logic                                 wr_overflow
);

  localparam int OFFSET_WIDTH = offset_width(BLOCK_SIZE);
  localparam int INDEX_WIDTH  = index_width(ADDR_WIDTH, BLOCK_SIZE);
  localparam int CNT_WIDTH    = $clog2(READ_LATENCY + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(READ_LATENCY);
  localparam logic [CNT_WIDTH-1:0] CNT_TC   = CNT_WIDTH'(1);

  typedef logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] blk_t;

  state_t                 state, state_nxt;
  logic [CNT_WIDTH-1:0]   cnt;
  logic [INDEX_WIDTH-1:0] req_idx, rd_idx;
  logic                   buf_valid;
  logic [INDEX_WIDTH-1:0] buf_idx;
  blk_t                   buf_data;
  logic                   fwd_hit;

  logic                   arr_we;
  logic [INDEX_WIDTH-1:0] arr_addr;
  blk_t                   arr_wdata, arr_rdata;

  logic accept, respond, buf_load, buf_commit, ovf_set;

  assign req_idx = mem_addr[ADDR_WIDTH-1:OFFSET_WIDTH];
  assign fwd_hit = buf_valid && (buf_idx == rd_idx);

  // Word-offset bits select nothing here; a block is always moved whole.
  generate
    if (OFFSET_WIDTH > 0) begin : g_offset
      logic offset_unused;
      assign offset_unused = ^mem_addr[OFFSET_WIDTH-1:0];
    end
  endgenerate

`ifdef MEM_ZERO_INIT_EN
  localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = '1;
  logic [INDEX_WIDTH-1:0] init_idx;

  // Fill pointer walks every block once after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  init_idx <= '0;
    else if (state == ST_INIT) init_idx <= init_idx + INDEX_WIDTH'(1);
  end

  assign mem_busy = (state == ST_INIT);
`else
  assign mem_busy = 1'b0;
`endif

  // State register; reset lands in the fill state only when it is built in.
  always_ff @(posedge clk or posedge rst) begin
`ifdef MEM_ZERO_INIT_EN
    if (rst) state <= ST_INIT;
`else
    if (rst) state <= ST_IDLE;
`endif
    else     state <= state_nxt;
  end

  // Next state, array port steering and datapath strobes.
  always_comb begin
    state_nxt  = state;
    arr_we     = 1'b0;
    arr_addr   = rd_idx;
    arr_wdata  = '0;
    accept     = 1'b0;
    respond    = 1'b0;
    buf_load   = 1'b0;
    buf_commit = 1'b0;
    ovf_set    = 1'b0;
    unique case (state)
`ifdef MEM_ZERO_INIT_EN
      ST_INIT: begin
        arr_we   = 1'b1;
        arr_addr = init_idx;
        if (init_idx == LAST_INDEX) state_nxt = ST_IDLE;
      end
`endif
      ST_IDLE: begin
        // The single port drains the buffer first; a write in the same cycle
        // refills the buffer and reads of that block are forwarded from it.
        if (buf_valid) begin
          arr_we     = 1'b1;
          arr_addr   = buf_idx;
          arr_wdata  = buf_data;
          buf_commit = 1'b1;
          buf_load   = mem_write;
        end else if (mem_write) begin
          arr_we    = 1'b1;
          arr_addr  = req_idx;
          arr_wdata = mem_data_out;
        end
        if (mem_read) begin
          accept    = 1'b1;
          state_nxt = ST_READ_WAIT;
        end
      end
      ST_READ_WAIT: begin
        if (cnt == CNT_TC) begin
          respond   = 1'b1;
          state_nxt = ST_RELEASE;
        end
        if (mem_write) begin
          if (buf_valid) ovf_set  = 1'b1;
          else           buf_load = 1'b1;
        end
      end
      ST_RELEASE: begin
        if (!mem_read) state_nxt = ST_IDLE;
        if (mem_write) begin
          if (buf_valid) ovf_set  = 1'b1;
          else           buf_load = 1'b1;
        end
      end
      default: state_nxt = state;
    endcase
  end

  // Read index capture and latency down-counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      rd_idx <= '0;
    end else if (accept) begin
      cnt    <= CNT_LOAD;
      rd_idx <= req_idx;
    end else if (state == ST_READ_WAIT) begin
      cnt <= cnt - CNT_WIDTH'(1);
    end
  end

  // Response pulse and held read data, forwarded from the buffer on a hit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_ready      <= 1'b0;
      mem_data_block <= '0;
    end else begin
      mem_ready <= respond;
      if (respond) mem_data_block <= fwd_hit ? buf_data : arr_rdata;
    end
  end

  // One-entry posted write buffer and sticky drop flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_valid   <= 1'b0;
      buf_idx     <= '0;
      buf_data    <= '0;
      wr_overflow <= 1'b0;
    end else begin
      if (buf_load) begin
        buf_valid <= 1'b1;
        buf_idx   <= req_idx;
        buf_data  <= mem_data_out;
      end else if (buf_commit) begin
        buf_valid <= 1'b0;
      end
      if (ovf_set) wr_overflow <= 1'b1;
    end
  end

  mem_block_array #(
    .DATA_WIDTH  (DATA_WIDTH),
    .BLOCK_SIZE  (BLOCK_SIZE),
    .INDEX_WIDTH (INDEX_WIDTH)
  ) u_array (
    .clk   (clk),
    .we    (arr_we & ~rst),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

endmodule

// File: tb/tb_mem_block_responder.sv
// Testbench for mem_block_responder: directed cache-like scenarios plus
// randomized traffic, checked every cycle against a transaction-level model.
import mem_pkg::*;

module tb_mem_block_responder;

  localparam int LAT  = 4;
  localparam int NBLK = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] mem_addr;
  logic        mem_read, mem_write;
  block_t      mem_data_out, mem_data_block;
  logic        mem_ready, mem_busy, wr_overflow;

  always #5 clk = ~clk;

  mem_block_responder #(
    .DATA_WIDTH   (32),
    .ADDR_WIDTH   (11),
    .BLOCK_SIZE   (32),
    .READ_LATENCY (LAT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_addr       (mem_addr),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_data_out   (mem_data_out),
    .mem_data_block (mem_data_block),
    .mem_ready      (mem_ready),
    .mem_busy       (mem_busy),
    .wr_overflow    (wr_overflow)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model (transaction level) ----------------
  typedef struct { int idx; block_t data; } pw_t;

  block_t m_mem [NBLK];
  pw_t    buf_q [$];
  int     m_edge = 0;
  int     m_init_left = 0;
  bit     m_rd_active = 0;
  bit     m_rel = 0;
  int     m_rd_idx = 0;
  int     m_rd_due = 0;
  bit     exp_ready = 0;
  bit     exp_ovf = 0;
  block_t exp_data = '0;

  function automatic bit m_idle();
    return (m_init_left == 0) && !m_rd_active && !m_rel;
  endfunction

  function automatic bit exp_busy();
    return m_init_left > 0;
  endfunction

  task automatic model_reset();
    buf_q.delete();
    m_rd_active = 0;
    m_rel       = 0;
    exp_ready   = 0;
    exp_ovf     = 0;
    exp_data    = '0;
`ifdef MEM_ZERO_INIT_EN
    m_init_left = NBLK;
`else
    m_init_left = 0;
`endif
  endtask

  task automatic model_step(input bit rd, input bit wr, input int idx, input block_t d);
    m_edge++;
    exp_ready = 0;
    if (m_init_left > 0) begin
      m_mem[NBLK - m_init_left] = '0;
      m_init_left--;
    end else if (m_rd_active || m_rel) begin
      if (m_rd_active && m_edge == m_rd_due) begin
        exp_ready = 1;
        if (buf_q.size() != 0 && buf_q[0].idx == m_rd_idx) exp_data = buf_q[0].data;
        else                                                exp_data = m_mem[m_rd_idx];
        m_rd_active = 0;
        m_rel       = 1;
      end else if (m_rel && !rd) begin
        m_rel = 0;
      end
      if (wr) begin
        if (buf_q.size() != 0) exp_ovf = 1;
        else                   buf_q.push_back('{idx, d});
      end
    end else begin
      if (buf_q.size() != 0) begin
        m_mem[buf_q[0].idx] = buf_q[0].data;
        void'(buf_q.pop_front());
      end
      if (wr) m_mem[idx] = d;
      if (rd) begin
        m_rd_active = 1;
        m_rd_idx    = idx;
        m_rd_due    = m_edge + LAT;
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_block(input string tag, input block_t obs, input block_t exp);
    int w = 0;
    for (int i = 31; i >= 0; i--) if (obs[i] !== exp[i]) w = i;
    chk(tag, {32'b0, obs[w]}, {32'b0, exp[w]});
  endtask

  function automatic block_t rand_block();
    block_t b;
    for (int i = 0; i < 32; i++) b[i] = $urandom;
    return b;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic cycle(input bit rd, input bit wr, input logic [10:0] a, input block_t d);
    // A write in the very cycle a buffered write drains is left untested.
    if (wr && m_idle() && buf_q.size() != 0) wr = 0;
    mem_read     = rd;
    mem_write    = wr;
    mem_addr     = a;
    mem_data_out = d;
    @(posedge clk);
    model_step(rd, wr, int'(a[10:5]), d);
    @(negedge clk);
    chk("ready", {63'b0, mem_ready}, {63'b0, exp_ready});
    chk("busy", {63'b0, mem_busy}, {63'b0, exp_busy()});
    chk("overflow", {63'b0, wr_overflow}, {63'b0, exp_ovf});
    chk_block("data", mem_data_block, exp_data);
  endtask

  task automatic do_reset();
    mem_read  = 0;
    mem_write = 0;
    rst       = 1;
    #1;
    chk("rst_ready", {63'b0, mem_ready}, 64'd0);
    chk("rst_overflow", {63'b0, wr_overflow}, 64'd0);
    chk_block("rst_data", mem_data_block, '0);
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_ready_hold", {63'b0, mem_ready}, 64'd0);
    end
`ifdef MEM_ZERO_INIT_EN
    chk("rst_busy", {63'b0, mem_busy}, 64'd1);
`else
    chk("rst_busy", {63'b0, mem_busy}, 64'd0);
`endif
    rst = 0;
    model_reset();
  endtask

  task automatic wait_free();
    int guard = 0;
    while (m_init_left > 0 && guard < 200) begin
      cycle(0, 0, 11'h0, '0);
      guard++;
    end
  endtask

  // Cache-style read: hold mem_read until mem_ready, one stale cycle, then drop.
  // Optional writes at given cycle numbers (1 = accept cycle) and optional reset.
  task automatic read_txn(input logic [10:0] ra, input block_t wf_data, input bit wr_first,
                          input int w1, input logic [10:0] a1,
                          input int w2, input logic [10:0] a2, input int rst_at);
    int k = 1;
    int lat = -1;
    int pulses = 0;
    bit done = 0;
    bit wr;
    logic [10:0] wa;
    block_t d;
    while (!done && k <= 40) begin
      if (k == rst_at) begin
        do_reset();
        done = 1;
      end else begin
        wr = 0;
        wa = ra;
        d  = rand_block();
        if (k == 1 && wr_first) begin wr = 1; d = wf_data; end
        if (k == w1) begin wr = 1; wa = a1; end
        if (k == w2) begin wr = 1; wa = a2; end
        cycle(1, wr, wa, d);
        if (mem_ready) begin
          pulses++;
          lat  = k - 1;
          done = 1;
        end
        k++;
      end
    end
    if (rst_at != 0 && k == rst_at) begin
      chk("rst_abort_pulses", pulses, 0);
    end else if (lat < 0) begin
      chk("rd_timeout", 0, 1);
    end else begin
      chk("latency", lat, LAT);
      cycle(1, 0, ra, '0);
      if (mem_ready) pulses++;
      repeat (2) begin
        cycle(0, 0, ra, '0);
        if (mem_ready) pulses++;
      end
      chk("ready_pulses", pulses, 1);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    block_t b;
    for (int i = 0; i < NBLK; i++) m_mem[i] = '0;
    mem_addr = '0; mem_read = 0; mem_write = 0; mem_data_out = '0;
    rst = 1;
    do_reset();
    wait_free();

`ifdef MEM_ZERO_INIT_EN
    read_txn(11'h0E0, '0, 0, 0, 11'h0, 0, 11'h0, 0);
    chk_block("init_zero", mem_data_block, '0);
`endif

    // Preload every block so later reads have defined contents.
    for (int i = 0; i < NBLK; i++) cycle(0, 1, 11'(i << 5), rand_block());

    // Simultaneous write and read of one block: read sees the new data.
    b = rand_block();
    read_txn(11'h100, b, 1, 0, 11'h0, 0, 11'h0, 0);
    chk_block("wr_rd_same_edge", mem_data_block, b);

    // Write pattern block, read back through a different offset in it.
    for (int i = 0; i < 32; i++) b[i] = 32'hA5A5_0000 + i;
    cycle(0, 1, 11'h040, b);
    read_txn(11'h05F, '0, 0, 0, 11'h0, 0, 11'h0, 0);
    chk_block("pattern_block", mem_data_block, b);

    // Back-to-back reads after the stale-cycle release.
    read_txn(11'h3E0, '0, 0, 0, 11'h0, 0, 11'h0, 0);
    read_txn(11'h020, '0, 0, 0, 11'h0, 0, 11'h0, 0);

    // Buffered write to 0x080 during another read, then read it back.
    read_txn(11'h300, '0, 0, 2, 11'h080, 0, 11'h0, 0);
    read_txn(11'h080, '0, 0, 0, 11'h0, 0, 11'h0, 0);
    // Forwarding: write lands in the buffer while its own block is being read.
    read_txn(11'h080, '0, 0, 3, 11'h080, 0, 11'h0, 0);
    read_txn(11'h080, '0, 0, 0, 11'h0, 0, 11'h0, 0);

    // Two writes in one read window: second dropped, overflow sticks.
    read_txn(11'h200, '0, 0, 2, 11'h0A0, 3, 11'h0C0, 0);
    chk("overflow_set", {63'b0, wr_overflow}, 64'd1);
    repeat (5) cycle(0, 0, 11'h0, '0);
    read_txn(11'h0C0, '0, 0, 0, 11'h0, 0, 11'h0, 0);

    // Reset two cycles into the read, with a buffered write pending.
    read_txn(11'h400, '0, 0, 2, 11'h120, 0, 11'h0, 4);
    chk("overflow_cleared", {63'b0, wr_overflow}, 64'd0);
    wait_free();
    read_txn(11'h120, '0, 0, 0, 11'h0, 0, 11'h0, 0);
`ifdef MEM_ZERO_INIT_EN
    for (int i = 0; i < NBLK; i++) cycle(0, 1, 11'(i << 5), rand_block());
`endif

    // Randomized traffic.
    for (int it = 0; it < 120; it++) begin
      int r = $urandom_range(0, 3);
      logic [10:0] ra = 11'($urandom);
      if (r == 0) begin
        cycle(0, 1, ra, rand_block());
      end else if (r == 1) begin
        cycle(0, 0, ra, '0);
      end else begin
        int w1 = ($urandom_range(0, 1) != 0) ? int'($urandom_range(2, LAT + 1)) : 0;
        int w2 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, LAT + 1)) : 0;
        read_txn(ra, rand_block(), $urandom_range(0, 1) != 0,
                 w1, 11'($urandom), w2, 11'($urandom), 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_block_responder.md
MEM_BLOCK_RESPONDER -- requirements
Module: mem_block_responder

Interface
REQ-001 The module SHALL use one clock and asynchronous active-high reset, with ports: clk  in  1  sole clock; rst  in  1  asynchronous active-high reset.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the word width.
REQ-003 Parameter ADDR_WIDTH, default 11, SHALL set the byte/word address width.
REQ-004 Parameter BLOCK_SIZE, default 32, SHALL set the words per block; OFFSET_WIDTH = clog2(BLOCK_SIZE).
REQ-005 Parameter READ_LATENCY, default 4, minimum 1, SHALL set the cycles from read acceptance to mem_ready.
REQ-006 Port mem_addr  in  ADDR_WIDTH SHALL carry the request address; offset bits are ignored, block index = mem_addr[ADDR_WIDTH-1:OFFSET_WIDTH].
REQ-007 Port mem_read  in  1 SHALL be the read request level, held by the cache until mem_ready.
REQ-008 Port mem_write  in  1 SHALL be the single-cycle write-through pulse.
REQ-009 Port mem_data_out  in  BLOCK_SIZE x DATA_WIDTH SHALL carry the write block, valid with mem_write.
REQ-010 Port mem_data_block  out  BLOCK_SIZE x DATA_WIDTH SHALL carry the read block, registered.
REQ-011 Port mem_ready  out  1 SHALL be a one-cycle read-completion pulse.
REQ-012 Port mem_busy  out  1 SHALL be high while requests are not accepted (INIT).
REQ-013 Port wr_overflow  out  1 SHALL be a sticky flag set when a write is dropped.

Function
REQ-014 Storage SHALL be 2^(ADDR_WIDTH-OFFSET_WIDTH) blocks (64 by default).
REQ-015 The FSM states SHALL be INIT, IDLE, READ_WAIT and RELEASE.
REQ-016 In IDLE, mem_read=1 SHALL latch the block index, load the latency counter with READ_LATENCY and enter READ_WAIT.
REQ-017 In READ_WAIT the counter SHALL decrement once per cycle; mem_ready=1 and mem_data_block=array[index] SHALL appear exactly READ_LATENCY cycles after the accepting edge; next state RELEASE.
REQ-018 In RELEASE, mem_read SHALL be ignored until it is sampled 0, then the FSM SHALL go to IDLE; this absorbs the cache's one-cycle stale mem_read after mem_ready.
REQ-019 mem_data_block SHALL hold its last value between responses.
REQ-020 A mem_write in IDLE SHALL commit mem_data_out to array[index] at that edge, with zero latency and no acknowledge.
REQ-021 When mem_write and mem_read occur together in IDLE, the write SHALL commit first and the read SHALL return the new data.
REQ-022 A mem_write in READ_WAIT or RELEASE SHALL be captured into a one-entry posted write buffer, which commits on the first IDLE cycle.
REQ-023 A read whose index matches a pending buffered write SHALL return the buffer data (forwarding).
REQ-024 A mem_write arriving while the buffer is occupied SHALL be dropped and SHALL set wr_overflow until reset.
REQ-025 mem_ready SHALL never assert without a preceding accepted read.

Reset
REQ-026 During reset: mem_ready=0, mem_data_block=0, wr_overflow=0, write buffer empty, counter 0.
REQ-027 After reset the state SHALL be INIT if MEM_ZERO_INIT_EN is defined, else IDLE with mem_busy=0.
REQ-028 Reset asserted mid-read SHALL abort the read with no mem_ready, and SHALL discard the pending buffered write.
REQ-029 Array contents SHALL NOT be reset by rst.

Configuration
REQ-030 Macro MEM_ZERO_INIT_EN defined: after reset, INIT SHALL write zero to one block per cycle, index 0 to max, with mem_busy=1 and requests ignored; then IDLE with mem_busy=0.
REQ-031 Macro MEM_ZERO_INIT_EN undefined: no INIT state, mem_busy tied 0, and array contents undefined until written.

Structure
REQ-032 Package mem_pkg SHALL hold the state encoding, OFFSET_WIDTH/index-width derivation functions and the block type.
REQ-033 Sub-module mem_block_array SHALL be a single-port block-wide storage array with synchronous write and combinational read; all control logic stays in mem_block_responder.

Verification
REQ-034 Write block 0xA5A5_0000+i to addr 0x040, then read 0x05F -> mem_ready exactly 4 cycles after acceptance, with data matching (same block).
REQ-035 Read held through mem_ready plus one stale cycle -> exactly one mem_ready pulse; a second read issued 2 cycles later is accepted.
REQ-036 Write to 0x080 during READ_WAIT, then read 0x080 -> forwarded data returned; array updated after return to IDLE.
REQ-037 Two writes during one READ_WAIT -> second dropped, wr_overflow=1 until rst.
REQ-038 rst asserted 2 cycles into READ_WAIT -> no mem_ready, outputs zero; with MEM_ZERO_INIT_EN, mem_busy=1 for 64 cycles and an unwritten block reads as 0.
REQ-039 Simultaneous mem_write and mem_read to 0x100 in IDLE -> read returns the written block after 4 cycles.
